// File: rtl/ludh_inst_loader_if.sv
// Stream and instruction-BRAM bus bundle for the LU-decomposition instruction loader.
// The loader is the master: it owns the BRAM port and accepts the word stream through s_ready.
interface ludh_inst_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic [31:0]           s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [31:0]           inst_din_part_0;
  logic [31:0]           inst_din_part_1;
  logic [31:0]           inst_dout_part_0;
  logic [31:0]           inst_dout_part_1;
  logic                  inst_en;
  logic                  inst_we;

  modport master (
    input  s_data, s_valid, s_last, inst_dout_part_0, inst_dout_part_1,
    output s_ready, inst_addr, inst_din_part_0, inst_din_part_1, inst_en, inst_we
  );

  modport slave (
    output s_data, s_valid, s_last, inst_dout_part_0, inst_dout_part_1,
    input  s_ready, inst_addr, inst_din_part_0, inst_din_part_1, inst_en, inst_we
  );
endinterface

// File: rtl/ludh_inst_loader.sv
// Packs 32-bit stream word pairs into 64-bit instruction BRAM writes, then runs the tester.
// Optional CRC read-back verification of the written program is enabled by LUDH_INST_VERIFY_EN.
module ludh_inst_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int CTRL_WIDTH = 60
) (
  input  logic                  CLK_100,
  input  logic                  RST_IN,
  input  logic                  arm,
  ludh_inst_loader_if.master    bus,
  output logic                  START,
  input  logic                  COMPLETED,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   inst_count
);

  localparam logic [63:0] HI_MASK_W = (64'd1 << (CTRL_WIDTH - 32)) - 64'd1;
  localparam logic [31:0] HI_MASK   = HI_MASK_W[31:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_LO,
    S_LOAD_HI,
    S_RUN,
    S_WAIT,
    S_DONE,
    S_ERROR
`ifdef LUDH_INST_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t      state;
  logic [31:0] lo_reg;
  logic [31:0] hi_masked;
  logic        overflow;
  logic        wr_fire;

  // inst_count doubles as the write address; its top bit means every slot is used.
  assign overflow  = inst_count[ADDR_WIDTH];
  assign hi_masked = bus.s_data & HI_MASK;
  assign wr_fire   = (state == S_LOAD_HI) && bus.s_valid && !overflow;

  assign bus.s_ready = (state == S_LOAD_LO) || (state == S_LOAD_HI);
  assign busy        = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

`ifdef LUDH_INST_VERIFY_EN
  logic [ADDR_WIDTH:0] rd_addr;
  logic                rd_pend;
  logic                rd_fire;
  logic [31:0]         crc_wr;
  logic [31:0]         crc_rd;

  assign rd_fire = (state == S_VERIFY) && (rd_addr < inst_count);

  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc ^ data;
    for (int i = 0; i < 32; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
`else
  logic unused_dout;
  assign unused_dout = ^{bus.inst_dout_part_0, bus.inst_dout_part_1};
`endif

  // The write is combinational with the accepted high word so no bubble is ever inserted.
  always_comb begin
    bus.inst_en         = wr_fire;
    bus.inst_we         = wr_fire;
    bus.inst_addr       = inst_count[ADDR_WIDTH-1:0];
    bus.inst_din_part_0 = wr_fire ? lo_reg : 32'd0;
    bus.inst_din_part_1 = wr_fire ? hi_masked : 32'd0;
`ifdef LUDH_INST_VERIFY_EN
    if (rd_fire) begin
      bus.inst_en   = 1'b1;
      bus.inst_addr = rd_addr[ADDR_WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge CLK_100 or negedge RST_IN) begin
    if (!RST_IN) begin
      state      <= S_IDLE;
      lo_reg     <= 32'd0;
      START      <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      inst_count <= '0;
`ifdef LUDH_INST_VERIFY_EN
      rd_addr    <= '0;
      rd_pend    <= 1'b0;
      crc_wr     <= 32'hFFFFFFFF;
      crc_rd     <= 32'hFFFFFFFF;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (arm) begin
            state      <= S_LOAD_LO;
            inst_count <= '0;
            error      <= 1'b0;
            err_code   <= 2'd0;
`ifdef LUDH_INST_VERIFY_EN
            crc_wr     <= 32'hFFFFFFFF;
`endif
          end
        end
        S_LOAD_LO: begin
          if (bus.s_valid) begin
            lo_reg <= bus.s_data;
            if (bus.s_last) begin
              state    <= S_ERROR;
              error    <= 1'b1;
              err_code <= 2'd1;
            end else begin
              state <= S_LOAD_HI;
            end
          end
        end
        S_LOAD_HI: begin
          if (bus.s_valid) begin
            if (overflow) begin
              state    <= S_ERROR;
              error    <= 1'b1;
              err_code <= 2'd2;
            end else begin
              inst_count <= inst_count + CNT_ONE;
`ifdef LUDH_INST_VERIFY_EN
              crc_wr <= crc32_word(crc32_word(crc_wr, lo_reg), hi_masked);
              if (bus.s_last) begin
                state   <= S_VERIFY;
                rd_addr <= '0;
                rd_pend <= 1'b0;
                crc_rd  <= 32'hFFFFFFFF;
              end else begin
                state <= S_LOAD_LO;
              end
`else
              state <= bus.s_last ? S_RUN : S_LOAD_LO;
`endif
            end
          end
        end
`ifdef LUDH_INST_VERIFY_EN
        // Reads issue one per cycle; data lands a cycle later and the verdict follows the last one.
        S_VERIFY: begin
          if (rd_fire) rd_addr <= rd_addr + CNT_ONE;
          rd_pend <= rd_fire;
          if (rd_pend) begin
            crc_rd <= crc32_word(crc32_word(crc_rd, bus.inst_dout_part_0), bus.inst_dout_part_1);
          end
          if (!rd_fire && !rd_pend) begin
            if (crc_rd == crc_wr) begin
              state <= S_RUN;
            end else begin
              state    <= S_ERROR;
              error    <= 1'b1;
              err_code <= 2'd3;
            end
          end
        end
`endif
        S_RUN: begin
          START <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (COMPLETED) begin
            START <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ludh_inst_loader.sv
// Self-checking bench for ludh_inst_loader: a word-list model predicts writes and outcome.
// Build with LUDH_INST_VERIFY_EN defined to also exercise the CRC read-back path.
module tb_ludh_inst_loader;

  localparam int          AW      = 2;
  localparam int          CW      = 60;
  localparam int          DEPTH   = 1 << AW;
  localparam logic [31:0] HI_MASK = 32'h0FFFFFFF;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   p0;
    logic [31:0]   p1;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          completed = 1'b0;
  logic          start;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   inst_count;

  int            checks = 0;
  int            errors = 0;
  bit            start_ok = 1'b0;
  bit            corrupt = 1'b0;
  wr_t           exp_q[$];
  wr_t           act_log[$];
  wr_t           cur_wr;
  wr_t           exp_wr;
  logic [31:0]   prog[$];
  logic [31:0]   mem0[DEPTH];
  logic [31:0]   mem1[DEPTH];

  ludh_inst_loader_if #(.ADDR_WIDTH(AW)) bus ();

  ludh_inst_loader #(.ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
    .CLK_100    (clk),
    .RST_IN     (rst_n),
    .arm        (arm),
    .bus        (bus),
    .START      (start),
    .COMPLETED  (completed),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  // BRAM model with one-cycle registered read; optionally flips bit 5 of address 1 on read.
  always @(posedge clk) begin
    if (bus.inst_en && bus.inst_we) begin
      mem0[bus.inst_addr] <= bus.inst_din_part_0;
      mem1[bus.inst_addr] <= bus.inst_din_part_1;
    end
    if (bus.inst_en) begin
      bus.inst_dout_part_0 <= mem0[bus.inst_addr] ^ ((corrupt && bus.inst_addr == AW'(1)) ? 32'h20 : 32'h0);
      bus.inst_dout_part_1 <= mem1[bus.inst_addr];
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every write the DUT makes is logged and matched against the model's expected write queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.inst_en && bus.inst_we) begin
        cur_wr = '{addr: bus.inst_addr, p0: bus.inst_din_part_0, p1: bus.inst_din_part_1};
        act_log.push_back(cur_wr);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got write at addr %0d, expected none", cur_wr.addr);
        end else begin
          exp_wr = exp_q.pop_front();
          check_output("wr_addr", 64'(cur_wr.addr), 64'(exp_wr.addr));
          check_output("wr_part_0", 64'(cur_wr.p0), 64'(exp_wr.p0));
          check_output("wr_part_1", 64'(cur_wr.p1), 64'(exp_wr.p1));
        end
      end
`ifndef LUDH_INST_VERIFY_EN
      if (bus.inst_en != bus.inst_we) begin
        checks++;
        errors++;
        $display("[TB] FAIL en_we_pair: got en=%0b we=%0b, expected equal", bus.inst_en, bus.inst_we);
      end
`endif
      if (start && !start_ok) begin
        checks++;
        errors++;
        $display("[TB] FAIL start_unexpected: got START=1, expected 0");
      end
    end
  end

  // Model: walk the word list beat by beat and derive writes, words consumed and the outcome.
  task automatic build_model(input bit has_last, output int consumed, output int writes,
                             output int code, output bit run);
    int n;
    n        = prog.size();
    consumed = 0;
    writes   = 0;
    code     = 0;
    run      = 1'b0;
    for (int k = 0; k < n; k++) begin
      consumed = k + 1;
      if (k % 2 == 0) begin
        if (has_last && k == n - 1) begin
          code = 1;
          break;
        end
      end else begin
        if (writes == DEPTH) begin
          code = 2;
          break;
        end
        exp_q.push_back('{addr: AW'(writes), p0: prog[k-1], p1: prog[k] & HI_MASK});
        writes++;
        if (has_last && k == n - 1) begin
          run = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input bit last, input bit gaps);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.s_data  = data;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    guard = 0;
    while (!bus.s_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got s_ready=0 for 50 cycles, expected 1");
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = $urandom;
  endtask

  task automatic apply_stimulus(input bit has_last, input bit gaps, input bit pre_comp, output int writes);
    int consumed, code;
    bit run;
    build_model(has_last, consumed, writes, code, run);
    start_ok = run;
    act_log.delete();
    do_arm();
    completed = pre_comp;
    for (int k = 0; k < consumed; k++) send_word(prog[k], has_last && (k == prog.size() - 1), gaps);
    if (run) begin
      check_output("start_after_last", 64'(start), 64'd0);
`ifdef LUDH_INST_VERIFY_EN
      repeat (writes + 2) begin
        @(posedge clk); #1;
      end
`endif
      @(posedge clk); #1;
      check_output("start_rise", 64'(start), 64'd1);
      check_output("busy_run", 64'(busy), 64'd1);
      if (!pre_comp) begin
        repeat (2) begin
          @(posedge clk); #1;
        end
        do_arm();
        check_output("start_hold_arm_ignored", 64'(start), 64'd1);
        check_output("busy_arm_ignored", 64'(busy), 64'd1);
        completed = 1'b1;
      end
      @(posedge clk); #1;
      completed = 1'b0;
      check_output("done_pulse", 64'(done), 64'd1);
      check_output("start_fall", 64'(start), 64'd0);
      check_output("busy_done", 64'(busy), 64'd0);
      check_output("error_clear", 64'(error), 64'd0);
      check_output("inst_count_done", 64'(inst_count), 64'(writes));
      start_ok = 1'b0;
      @(posedge clk); #1;
      check_output("done_one_cycle", 64'(done), 64'd0);
    end else begin
      completed = 1'b0;
      check_output("error_flag", 64'(error), 64'd1);
      check_output("err_code", 64'(err_code), 64'(code));
      check_output("s_ready_error", 64'(bus.s_ready), 64'd0);
      check_output("start_error", 64'(start), 64'd0);
      check_output("busy_error", 64'(busy), 64'd0);
      check_output("inst_count_error", 64'(inst_count), 64'(writes));
      bus.s_valid = 1'b1;
      repeat (2) begin
        @(posedge clk); #1;
      end
      check_output("s_ready_held_low", 64'(bus.s_ready), 64'd0);
      check_output("inst_count_hold", 64'(inst_count), 64'(writes));
      bus.s_valid = 1'b0;
    end
    check_output("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int writes, consumed, code;
    bit run;
    bus.s_data  = 32'd0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_start", 64'(start), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_error", 64'(error), 64'd0);
    check_output("rst_err_code", 64'(err_code), 64'd0);
    check_output("rst_inst_count", 64'(inst_count), 64'd0);
    check_output("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check_output("rst_inst_en", 64'(bus.inst_en), 64'd0);
    check_output("rst_inst_we", 64'(bus.inst_we), 64'd0);
    check_output("rst_inst_addr", 64'(bus.inst_addr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic load");
    prog = {32'h11111111, 32'h02222222, 32'h33333333, 32'h0F444444};
    apply_stimulus(1'b1, 1'b0, 1'b0, writes);
    check_output("basic_writes", 64'(act_log.size()), 64'd2);
    check_output("basic_a0_lo", 64'(act_log[0].p0), 64'h11111111);
    check_output("basic_a0_hi", 64'(act_log[0].p1), 64'h02222222);
    check_output("basic_a1_addr", 64'(act_log[1].addr), 64'd1);
    check_output("basic_a1_lo", 64'(act_log[1].p0), 64'h33333333);
    check_output("basic_a1_hi", 64'(act_log[1].p1), 64'h0F444444);

    $display("[TB] masking with COMPLETED already high");
    prog = {32'hAAAAAAAA, 32'hFFFFFFFF};
    apply_stimulus(1'b1, 1'b0, 1'b1, writes);
    check_output("mask_hi", 64'(act_log[0].p1), 64'h0FFFFFFF);

    $display("[TB] odd word count");
    prog = {32'h00000001, 32'h00000002, 32'h00000003};
    apply_stimulus(1'b1, 1'b0, 1'b0, writes);
    check_output("odd_writes", 64'(act_log.size()), 64'd1);

    $display("[TB] address overflow");
    prog.delete();
    for (int i = 0; i < 10; i++) prog.push_back(32'h00A00000 + 32'(i));
    apply_stimulus(1'b0, 1'b0, 1'b0, writes);
    check_output("ovf_writes", 64'(act_log.size()), 64'd4);
    check_output("ovf_last_addr", 64'(act_log[3].addr), 64'd3);

    $display("[TB] backpressure gaps");
    prog = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    apply_stimulus(1'b1, 1'b1, 1'b0, writes);
    check_output("bp_writes", 64'(act_log.size()), 64'd3);

    $display("[TB] reset during WAIT");
    prog = {32'hCAFE0001, 32'h0BAD0002};
    build_model(1'b1, consumed, writes, code, run);
    start_ok = run;
    do_arm();
    send_word(prog[0], 1'b0, 1'b0);
    send_word(prog[1], 1'b1, 1'b0);
`ifdef LUDH_INST_VERIFY_EN
    repeat (writes + 2) begin
      @(posedge clk); #1;
    end
`endif
    @(posedge clk); #1;
    check_output("rst_wait_start_pre", 64'(start), 64'd1);
    rst_n = 1'b0;
    #1;
    check_output("rst_wait_start", 64'(start), 64'd0);
    check_output("rst_wait_busy", 64'(busy), 64'd0);
    check_output("rst_wait_count", 64'(inst_count), 64'd0);
    start_ok = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    prog = {32'h11111111, 32'h02222222, 32'h33333333, 32'h0F444444};
    apply_stimulus(1'b1, 1'b0, 1'b0, writes);
    check_output("rearm_addr0", 64'(act_log[0].addr), 64'd0);

`ifdef LUDH_INST_VERIFY_EN
    $display("[TB] verify with corrupted read-back");
    corrupt = 1'b1;
    build_model(1'b1, consumed, writes, code, run);
    start_ok = 1'b0;
    do_arm();
    for (int k = 0; k < consumed; k++) send_word(prog[k], k == prog.size() - 1, 1'b0);
    repeat (writes + 3) begin
      @(posedge clk); #1;
    end
    check_output("verify_error", 64'(error), 64'd1);
    check_output("verify_err_code", 64'(err_code), 64'd3);
    check_output("verify_start", 64'(start), 64'd0);
    check_output("verify_drained", 64'(exp_q.size()), 64'd0);
    corrupt = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
